// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and fetch sequencer with IDLE/RUN/DONE control
// Advances, redirects or holds the PC each cycle; counts retired instructions.
module pc_fetch_ctrl #(
  parameter int D  = 12,
  parameter int LA = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          branch_taken,
  input  logic [LA-1:0] branch_idx,
  input  logic [D-1:0]  lut_target,
  output logic [LA-1:0] lut_addr,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] inst_count,
  output logic          bad_branch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          taken;
  logic [CW-1:0] count_next;

  assign lut_addr = branch_idx;
  assign taken    = branch_en & branch_taken;

  // Counter sticks at all-ones rather than wrapping.
  assign count_next = (inst_count == {CW{1'b1}}) ? inst_count : inst_count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prog_ctr   <= '0;
      inst_count <= '0;
      bad_branch <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            prog_ctr   <= start_addr;
            inst_count <= '0;
            bad_branch <= 1'b0;
            state      <= RUN;
            running    <= 1'b1;
            done       <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            inst_count <= count_next;
            if (halt) begin
              // PC stays on the halt instruction.
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (taken && (branch_idx != '0)) begin
              prog_ctr <= lut_target;
            end else begin
              if (taken) bad_branch <= 1'b1;
              prog_ctr <= prog_ctr + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl
// Stimulus queues expected post-edge state; a monitor pops and compares after each edge.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] start_addr;
  logic        stall;
  logic        halt;
  logic        branch_en;
  logic        branch_taken;
  logic [4:0]  branch_idx;
  logic [11:0] lut_target;
  logic [4:0]  lut_addr;
  logic [11:0] prog_ctr;
  logic        running;
  logic        done;
  logic [15:0] inst_count;
  logic        bad_branch;

  pc_fetch_ctrl #(.D(12), .LA(5), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .stall(stall), .halt(halt), .branch_en(branch_en), .branch_taken(branch_taken),
    .branch_idx(branch_idx), .lut_target(lut_target), .lut_addr(lut_addr),
    .prog_ctr(prog_ctr), .running(running), .done(done),
    .inst_count(inst_count), .bad_branch(bad_branch)
  );

  typedef struct {
    string       name;
    logic [11:0] pc;
    logic [15:0] cnt;
    logic        run;
    logic        dn;
    logic        bad;
    logic [4:0]  la;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one comparison per queued expectation, sampled 1 unit after the event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (prog_ctr !== e.pc || inst_count !== e.cnt || running !== e.run ||
            done !== e.dn || bad_branch !== e.bad || lut_addr !== e.la) begin
          errors++;
          $display("FAIL %s: got pc=%0d cnt=%0d run=%b done=%b bad=%b la=%0d, want pc=%0d cnt=%0d run=%b done=%b bad=%b la=%0d",
                   e.name, prog_ctr, inst_count, running, done, bad_branch, lut_addr,
                   e.pc, e.cnt, e.run, e.dn, e.bad, e.la);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, want completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  task automatic expect_next(input string nm, input int pc, input int cnt,
                             input bit run, input bit dn, input bit bad);
    exp_t e;
    e.name = nm;
    e.pc   = pc[11:0];
    e.cnt  = cnt[15:0];
    e.run  = run;
    e.dn   = dn;
    e.bad  = bad;
    e.la   = branch_idx;
    exp_q.push_back(e);
  endtask

  task automatic tick(input string nm, input int pc, input int cnt,
                      input bit run, input bit dn, input bit bad);
    expect_next(nm, pc, cnt, run, dn, bad);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; halt = 0; branch_en = 0; branch_taken = 0;
    branch_idx = 0; lut_target = 0;
  endtask

  initial begin
    reset = 1;
    start_addr = 0;
    clear_inputs();
    tick("reset_state", 0, 0, 0, 0, 0);
    reset = 0;
    tick("idle_after_reset", 0, 0, 0, 0, 0);

    // Run up to PC=37, then abort with an asynchronous reset mid-cycle.
    start = 1; start_addr = 30;
    tick("start_30", 30, 0, 1, 0, 0);
    start = 0;
    for (int i = 1; i <= 7; i++) tick("seq_to_37", 30 + i, i, 1, 0, 0);
    #2;
    expect_next("async_reset", 0, 0, 0, 0, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;

    // Straight-line program of 8 then halt.
    start = 1; start_addr = 0;
    tick("start_0", 0, 0, 1, 0, 0);
    start = 0;
    for (int i = 1; i <= 8; i++) tick("seq_0_8", i, i, 1, 0, 0);
    halt = 1;
    tick("halt_at_8", 8, 9, 0, 1, 0);
    halt = 0;
    tick("done_hold", 8, 9, 0, 1, 0);

    // Taken branch from PC=4 through index 3.
    start = 1; start_addr = 4;
    tick("start_4", 4, 0, 1, 0, 0);
    start = 0;
    branch_en = 1; branch_taken = 1; branch_idx = 3; lut_target = 48;
    tick("taken_branch", 48, 1, 1, 0, 0);
    clear_inputs();
    tick("after_branch", 49, 2, 1, 0, 0);
    halt = 1; branch_en = 1; branch_taken = 1; branch_idx = 3; lut_target = 48;
    tick("halt_beats_branch", 49, 3, 0, 1, 0);
    clear_inputs();

    // Not-taken branch at PC=10.
    start = 1; start_addr = 10;
    tick("start_10", 10, 0, 1, 0, 0);
    start = 0;
    branch_en = 1; branch_taken = 0; branch_idx = 7; lut_target = 99;
    tick("not_taken", 11, 1, 1, 0, 0);
    clear_inputs();
    halt = 1;
    tick("halt_at_11", 11, 2, 0, 1, 0);
    halt = 0;

    // Taken branch through reserved index 0 at PC=20.
    start = 1; start_addr = 20;
    tick("start_20", 20, 0, 1, 0, 0);
    start = 0;
    branch_en = 1; branch_taken = 1; branch_idx = 0; lut_target = 77;
    tick("bad_branch", 21, 1, 1, 0, 1);
    clear_inputs();
    tick("bad_sticky", 22, 2, 1, 0, 1);
    halt = 1;
    tick("bad_in_done", 22, 3, 0, 1, 1);
    halt = 0;
    tick("bad_done_hold", 22, 3, 0, 1, 1);

    // Stall at PC=15 with halt and branch present; halt wins once released.
    start = 1; start_addr = 15;
    tick("start_15_clr_bad", 15, 0, 1, 0, 0);
    start = 0;
    stall = 1; halt = 1; branch_en = 1; branch_taken = 1; branch_idx = 2; lut_target = 200;
    for (int i = 0; i < 3; i++) tick("stall_hold", 15, 0, 1, 0, 0);
    stall = 0;
    tick("halt_after_stall", 15, 1, 0, 1, 0);
    clear_inputs();

    // Restart from DONE with start held through RUN.
    start = 1; start_addr = 100;
    tick("restart_100", 100, 0, 1, 0, 0);
    tick("start_in_run", 101, 1, 1, 0, 0);
    start = 0;
    halt = 1;
    tick("halt_at_101", 101, 2, 0, 1, 0);
    halt = 0;

    // PC wrap from 4095.
    start = 1; start_addr = 4095;
    tick("start_4095", 4095, 0, 1, 0, 0);
    start = 0;
    tick("pc_wrap", 0, 1, 1, 0, 0);
    tick("pc_after_wrap", 1, 2, 1, 0, 0);

    // Long run to saturate the counter.
    repeat (65531) @(negedge clk);
    tick("cnt_65534", 4093, 65534, 1, 0, 0);
    tick("cnt_65535", 4094, 65535, 1, 0, 0);
    tick("cnt_saturate", 4095, 65535, 1, 0, 0);
    tick("cnt_sat_wrap", 0, 65535, 1, 0, 0);
    halt = 1;
    tick("halt_saturated", 0, 65535, 0, 1, 0);
    halt = 0;

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-sequencing stage that sits directly downstream of the branch-target lookup table and drives instruction-memory addressing. It holds the PC and a three-state run controller (IDLE/RUN/DONE) with a start/done handshake to the testbench. Each cycle it either advances the PC, loads an absolute target supplied by the lookup table, or holds on stall or halt. It also keeps a saturating executed-instruction counter and a sticky error flag for branches through the reserved table index 0.

## Interface
- D, 12, PC width in bits; must match the lookup table target width.
- LA, 5, lookup-table index width.
- CW, 16, instruction-counter width.

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  level-sampled request to begin a program; acted on only in IDLE or DONE.
- start_addr  input  D  PC value loaded when start is accepted.
- stall  input  1  in RUN, freeze the PC and counter for this cycle.
- halt  input  1  decoded halt instruction at the current PC.
- branch_en  input  1  decoded branch instruction at the current PC.
- branch_taken  input  1  branch condition result (ALU flag), same cycle.
- branch_idx  input  LA  table index field from the current instruction.
- lut_target  input  D  absolute target returned by the lookup table for lut_addr.
- lut_addr  output  LA  index presented to the lookup table; combinationally equal to branch_idx.
- prog_ctr  output  D  current PC, registered; addresses instruction memory.
- running  output  1  1 while in RUN.
- done  output  1  1 while in DONE.
- inst_count  output  CW  instructions retired since the last accepted start.
- bad_branch  output  1  sticky: a taken branch used index 0.

## Operation
- States: IDLE (encoding 0), RUN, DONE. running and done are decoded from the state register and are registered outputs, not combinational from inputs.
- Reset (asynchronous, takes effect at once):
  - state=IDLE, prog_ctr=0, inst_count=0, bad_branch=0.
  - This yields running=0 and done=0.
  - Reset asserted mid-RUN aborts the program. No partial update survives.
- IDLE / DONE, start=1:
  - prog_ctr<=start_addr; inst_count<=0; bad_branch<=0; state<=RUN.
  - The other RUN-path inputs are ignored in that cycle.
- IDLE / DONE, start=0: all state holds. In DONE, done stays 1 indefinitely.
- RUN, evaluated once per cycle. The first matching rule applies, in this priority order:
  1. stall=1: prog_ctr and inst_count hold; halt and branch are ignored.
  2. halt=1: state<=DONE; prog_ctr holds (it points at the halt instruction); inst_count+=1.
  3. branch_en=1 and branch_taken=1 and branch_idx!=0: prog_ctr<=lut_target; inst_count+=1.
  4. branch_en=1 and branch_taken=1 and branch_idx==0: bad_branch<=1; prog_ctr<=prog_ctr+1; inst_count+=1.
  5. Otherwise (including branch_en with branch_taken=0): prog_ctr<=prog_ctr+1; inst_count+=1.
- start is ignored while in RUN.
- Arithmetic:
  - prog_ctr+1 wraps modulo 2^D; 2^D-1 advances to 0 with no flag.
  - inst_count saturates at 2^CW-1 and never wraps.
  - lut_target is used unmodified; it is not an offset.

## Timing
- lut_addr has zero latency: it is combinational from branch_idx. The table is combinational, so lut_target is valid in the same cycle.
- PC update latency is one cycle: the redirect or increment is visible on prog_ctr after the next rising edge.
- Branch penalty is zero bubbles. There is no pipeline; fetch is single-cycle.
- Handshake:
  - start sampled high in IDLE/DONE → running=1 on the following cycle, with prog_ctr=start_addr.
  - halt sampled in RUN (no stall) → done=1 and running=0 on the following cycle.
- Start-to-done latency for a straight-line program of N instructions ending in halt, with no stalls: N cycles of RUN. inst_count=N at done.
- Simultaneous events:
  - start held high continuously restarts exactly once per DONE entry: DONE with start=1 re-enters RUN on the next edge.
  - halt and a taken branch together resolve as halt.
  - stall and halt together resolve as stall; the halt is re-evaluated the next cycle.
- reset deassertion: the first active edge after deassertion sees IDLE.

## Test plan
- Reset and basic run:
  - Stimulus: assert reset mid-RUN with prog_ctr=37; release; start=1 with start_addr=0; feed 8 non-branch instructions, then halt.
  - Response: outputs zero immediately on reset; prog_ctr steps 0..8 and holds at 8; done=1; inst_count=9.
- Taken branch:
  - Stimulus: at PC=4, branch_en=1, branch_taken=1, branch_idx=3, lut_target=48.
  - Response: lut_addr=3 in the same cycle; prog_ctr=48 next cycle.
- Not-taken branch and bad index:
  - Stimulus (a): branch_taken=0 at PC=10.
  - Response (a): PC becomes 11.
  - Stimulus (b): branch_taken=1 with branch_idx=0 at PC=20.
  - Response (b): PC becomes 21; bad_branch=1 until the next accepted start.
- Stall priority:
  - Stimulus: stall=1 for 3 cycles at PC=15, with halt=1 and branch asserted during the stall; then release with halt=1.
  - Response: PC stays 15 and inst_count is frozen for 3 cycles; DONE is entered on the first unstalled cycle.
- Wrap and saturation:
  - Stimulus (a): start_addr=4095, with no branch.
  - Response (a): PC becomes 0.
  - Stimulus (b): force a run longer than 65535 cycles.
  - Response (b): inst_count holds at 65535.
- Restart from DONE:
  - Stimulus: in DONE, start=1 with start_addr=100; start=1 during RUN.
  - Response: running=1 and PC=100 next cycle; inst_count=0, bad_branch=0; the start pulse during RUN has no effect.
